// File: rtl/top4_accum.sv
// top4_accum
//   Streaming top-4 accumulator fed by the 4-byte sorting network. Keeps the
//   four best bytes of the current frame in rank order and emits them, with
//   a saturating word count, on the frame's last word. No backpressure.
//
//   Parameters
//     KEEP_MAX  1: keep the four largest bytes, 0: keep the four smallest
//     CNT_W     width of the frame word counter
//   Ports
//     clk        clock, rising edge
//     rst_n      synchronous active-low reset
//     in_valid   in_word / in_last valid this cycle
//     in_word    sorted word, [31:24] is rank 0 (best)
//     in_last    last word of the frame (qualified by in_valid)
//     out_valid  one-cycle result pulse
//     out_word   best four bytes of the frame, same layout as in_word
//     out_count  valid words in the frame, saturating
//     out_sat    out_count saturated during this frame

// Compare-swap cell: the better byte goes to hi, the other to lo.
module top4_cas #(
    parameter bit KEEP_MAX = 1'b1
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] hi,
    output logic [7:0] lo
);
    logic b_better;
    assign b_better = KEEP_MAX ? (b > a) : (b < a);
    assign hi = b_better ? b : a;
    assign lo = b_better ? a : b;
endmodule

module top4_accum #(
    parameter bit KEEP_MAX = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_word,
    input  logic             in_last,
    output logic             out_valid,
    output logic [31:0]      out_word,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);
    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t state, state_nx;

    // Internal byte arrays are indexed by rank (index 0 = best).
    logic [3:0][7:0]   acc, acc_nx, w, c, d, m;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic              sat, sat_nx, sat_inc, cnt_full;
    logic              emit, emit_sat;
    logic [31:0]       emit_word;
    logic [CNT_W-1:0]  emit_cnt;

    function automatic logic better(input logic [7:0] a, input logic [7:0] b);
        return KEEP_MAX ? (a > b) : (a < b);
    endfunction

    function automatic logic [31:0] to_word(input logic [3:0][7:0] r);
        return {r[0], r[1], r[2], r[3]};
    endfunction

    assign w = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};

    // Level 1: pairing acc rank i with input rank 3-i and keeping the better
    // of each pair yields exactly the top four of the eight, as a bitonic
    // sequence. Levels 2 and 3 finish the 4-element bitonic sort.
    for (genvar i = 0; i < 4; i++) begin : g_l1
        assign c[i] = better(w[3-i], acc[i]) ? w[3-i] : acc[i];
    end
    for (genvar i = 0; i < 2; i++) begin : g_l2
        top4_cas #(.KEEP_MAX(KEEP_MAX)) u_cas (
            .a(c[i]), .b(c[i+2]), .hi(d[i]), .lo(d[i+2])
        );
    end
    for (genvar i = 0; i < 2; i++) begin : g_l3
        top4_cas #(.KEEP_MAX(KEEP_MAX)) u_cas (
            .a(d[2*i]), .b(d[2*i+1]), .hi(m[2*i]), .lo(m[2*i+1])
        );
    end

    // Saturating increment: an all-ones counter holds and flags saturation.
    assign cnt_full = &cnt;
    assign cnt_inc  = cnt_full ? cnt : cnt + CNT_W'(1);
    assign sat_inc  = sat | cnt_full;

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        sat_nx    = sat;
        emit      = 1'b0;
        emit_word = in_word;
        emit_cnt  = CNT_W'(1);
        emit_sat  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    if (in_last) begin
                        // One-word frame passes straight through.
                        emit = 1'b1;
                    end else begin
                        acc_nx   = w;
                        cnt_nx   = CNT_W'(1);
                        sat_nx   = 1'b0;
                        state_nx = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (in_last) begin
                        emit      = 1'b1;
                        emit_word = to_word(m);
                        emit_cnt  = cnt_inc;
                        emit_sat  = sat_inc;
                        state_nx  = EMPTY;
                    end else begin
                        acc_nx = m;
                        cnt_nx = cnt_inc;
                        sat_nx = sat_inc;
                    end
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            sat       <= sat_nx;
            out_valid <= emit;
            // Result fields hold between pulses.
            if (emit) begin
                out_word  <= emit_word;
                out_count <= emit_cnt;
                out_sat   <= emit_sat;
            end
        end
    end
endmodule

// File: tb/tb_top4_accum.sv
module tb_top4_accum;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_last;
    logic [31:0] in_word, in_word_r;

    logic        mx_v, mn_v, st_v;
    logic [31:0] mx_w, mn_w, st_w;
    logic [15:0] mx_c, mn_c;
    logic [1:0]  st_c;
    logic        mx_s, mn_s, st_s;

    always #5 clk = ~clk;

    // Min-mode instance sees the same bytes in ascending rank order.
    assign in_word_r = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};

    top4_accum #(.KEEP_MAX(1'b1), .CNT_W(16)) u_max (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .out_valid(mx_v), .out_word(mx_w), .out_count(mx_c), .out_sat(mx_s));
    top4_accum #(.KEEP_MAX(1'b0), .CNT_W(16)) u_min (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word_r), .in_last(in_last),
        .out_valid(mn_v), .out_word(mn_w), .out_count(mn_c), .out_sat(mn_s));
    top4_accum #(.KEEP_MAX(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .out_valid(st_v), .out_word(st_w), .out_count(st_c), .out_sat(st_s));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every byte of the current frame in a queue; on the
    // last word the whole frame is sorted and the four best are taken.
    int unsigned fb[$];
    int          n = 0;
    logic        exp_v = 1'b0;
    logic [31:0] exp_mx = '0, exp_mn = '0, exp_c16 = '0, exp_c2 = '0;
    logic        exp_s16 = 1'b0, exp_s2 = 1'b0;

    task automatic tick();
        int unsigned s[$];
        int unsigned t;
        if (!rst_n) begin
            fb.delete();
            n = 0;
            exp_v = 1'b0; exp_mx = '0; exp_mn = '0;
            exp_c16 = '0; exp_c2 = '0; exp_s16 = 1'b0; exp_s2 = 1'b0;
        end else if (in_valid) begin
            for (int b = 0; b < 4; b++) fb.push_back(int'(in_word[31-8*b -: 8]));
            n++;
            if (in_last) begin
                s = fb;
                s.rsort();
                exp_mx = '0;
                for (int k = 0; k < 4; k++) begin t = s[k]; exp_mx = (exp_mx << 8) | t; end
                s.sort();
                exp_mn = '0;
                for (int k = 0; k < 4; k++) begin t = s[k]; exp_mn = (exp_mn << 8) | t; end
                exp_c16 = (n > 65535) ? 65535 : n;
                exp_s16 = (n > 65535);
                exp_c2  = (n > 3) ? 3 : n;
                exp_s2  = (n > 3);
                exp_v   = 1'b1;
                fb.delete();
                n = 0;
            end else exp_v = 1'b0;
        end else exp_v = 1'b0;
        @(posedge clk);
        #1;
        chk("max_valid", 32'(mx_v), 32'(exp_v));
        chk("max_word",  mx_w, exp_mx);
        chk("max_count", 32'(mx_c), exp_c16);
        chk("max_sat",   32'(mx_s), 32'(exp_s16));
        chk("min_valid", 32'(mn_v), 32'(exp_v));
        chk("min_word",  mn_w, exp_mn);
        chk("min_count", 32'(mn_c), exp_c16);
        chk("min_sat",   32'(mn_s), 32'(exp_s16));
        chk("sat_valid", 32'(st_v), 32'(exp_v));
        chk("sat_word",  st_w, exp_mx);
        chk("sat_count", 32'(st_c), exp_c2);
        chk("sat_sat",   32'(st_s), 32'(exp_s2));
    endtask

    task automatic send(input logic [31:0] w, input logic last);
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_word  = $urandom;
            tick();
        end
    endtask

    // Random word with bytes sorted descending; biased toward duplicates
    // and the 0x00 / 0xFF extremes.
    function automatic logic [31:0] rnd_word();
        logic [7:0] b[4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 5))
                0: b[i] = 8'h00;
                1: b[i] = 8'hFF;
                2: b[i] = 8'h50;
                default: b[i] = 8'($urandom_range(0, 255));
            endcase
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (b[j] < b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    initial begin
        int len;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_word = '0;
        tick(); tick();
        chk("rst_valid", 32'(mx_v), 32'd0);
        chk("rst_word",  mx_w, 32'd0);
        chk("rst_count", 32'(mx_c), 32'd0);
        chk("rst_sat",   32'(mx_s), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-word frame, then the pulse drops.
        send(32'h40302010, 1'b1);
        chk("one_valid", 32'(mx_v), 32'd1);
        chk("one_word",  mx_w, 32'h40302010);
        chk("one_count", 32'(mx_c), 32'd1);
        chk("one_sat",   32'(mx_s), 32'd0);
        idle(1);
        chk("one_drop",  32'(mx_v), 32'd0);
        chk("one_hold",  mx_w, 32'h40302010);

        // Two-word merge.
        send(32'h90605030, 1'b0);
        send(32'h80706010, 1'b1);
        chk("two_word",  mx_w, 32'h90807060);
        chk("two_count", 32'(mx_c), 32'd2);

        // Gaps and duplicates.
        send(32'h50505050, 1'b0);
        idle(2);
        send(32'h50504040, 1'b1);
        chk("dup_word",  mx_w, 32'h50505050);
        chk("dup_count", 32'(mx_c), 32'd2);

        // Min mode: min instance sees 0x01030507 then 0x02040608.
        send(32'h07050301, 1'b0);
        send(32'h08060402, 1'b1);
        chk("min_mode",  mn_w, 32'h01020304);

        // Reset mid-frame discards the partial frame.
        send(32'hFF000000, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(mx_v), 32'd0);
        send(32'h10080402, 1'b1);
        chk("mid_rst_word",  mx_w, 32'h10080402);
        chk("mid_rst_count", 32'(mx_c), 32'd1);

        // Saturation on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) send(32'h0, i == 4);
        chk("sat_count5", 32'(st_c), 32'd3);
        chk("sat_flag5",  32'(st_s), 32'd1);
        send(32'h44332211, 1'b1);
        chk("sat_clear",  32'(st_s), 32'd0);
        chk("sat_cnt1",   32'(st_c), 32'd1);

        // Back-to-back one-word frames.
        send(32'h0A090807, 1'b1);
        send(32'hFFEEDDCC, 1'b1);
        chk("b2b_valid", 32'(mx_v), 32'd1);
        chk("b2b_word",  mx_w, 32'hFFEEDDCC);

        // Randomized frames with gaps and occasional mid-frame reset.
        for (int f = 0; f < 300; f++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 12) : $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                if ($urandom_range(0, 60) == 0) begin
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                end
                send(rnd_word(), i == len - 1);
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/top4_accum.md
# top4_accum

Streaming top-4 accumulator that sits directly downstream of the 4-byte sorting network. It consumes one sorted packed word (four unsigned bytes) per valid cycle and keeps a running sorted set of the four best bytes seen in the current frame. On the frame's last word it emits the four best bytes of the whole frame plus a word count. The block has no backpressure, matching the fixed-latency, non-stalling sorter that feeds it.

## Interface
- `KEEP_MAX`, default 1: 1 keeps the four largest bytes; 0 keeps the four smallest.
- `CNT_W`, default 16: width of the frame word counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `in_word` / `in_last` are valid this cycle.
- `in_word`  in  32  sorted input. `[31:24]` is rank 0 (best), `[7:0]` is rank 3. Order is descending when `KEEP_MAX`=1, ascending when 0.
- `in_last`  in  1  qualified by `in_valid`; marks the final word of a frame.
- `out_valid`  out  1  one-cycle pulse; result valid.
- `out_word`  out  32  frame's best four bytes, same rank layout as `in_word`.
- `out_count`  out  CNT_W  number of valid words in the emitted frame, saturating.
- `out_sat`  out  1  `out_count` saturated during this frame.

## Operation
- **"Better" relation:**
  - `KEEP_MAX`=1: `a` is better than `b` when `a > b`, unsigned.
  - `KEEP_MAX`=0: `a` is better than `b` when `a < b`.
  - Ties keep both bytes; duplicates are retained.
- **State:**
  - `acc[0..3]`: running best, rank order.
  - `cnt`: CNT_W bits.
  - `sat`: 1 bit.
  - FSM states: EMPTY and ACCUM.
- **Merge function `M(acc, w)`:** one combinational cycle with three compare levels.
  - Level 1: `c[i] = better(acc[i], w[3-i])` for i = 0..3. The result is a bitonic sequence.
  - Level 2: compare-swap `(c0,c2)` and `(c1,c3)`.
  - Level 3: compare-swap `(c0,c1)` and `(c2,c3)`.
  - Result is in rank order.
- **EMPTY:**
  - `in_valid` && !`in_last`: `acc <= in_word`, `cnt <= 1`, `sat <= 0`, go to ACCUM.
  - `in_valid` && `in_last` (one-word frame): emit `out_word = in_word`, `out_count = 1`, `out_sat = 0`; stay in EMPTY.
- **ACCUM:**
  - `in_valid` && !`in_last`: `acc <= M(acc, in_word)`, `cnt <= cnt+1`.
    - If `cnt` is all-ones, `cnt` holds and `sat <= 1`.
  - `in_valid` && `in_last`: emit `M(acc, in_word)`, `cnt+1` (saturating, with `sat` updated the same way), go to EMPTY.
- `in_valid`=0: all state holds; `in_last` is ignored.
- The accumulator is never cleared to an identity value. EMPTY loads the word directly, so 0x00 and 0xFF inputs are handled exactly.
- The block does not check that `in_word` is sorted. Unsorted input gives undefined rank order, but no lockup.

## Timing
- **Reset** (`rst_n`=0 at a rising edge), including mid-frame:
  - `out_valid`=0, `out_word`=0, `out_count`=0, `out_sat`=0.
  - `acc`=0, `cnt`=0, `sat`=0, state EMPTY.
  - The partial frame is discarded and no result is emitted for it.
- **Latency:** a result is registered on the edge that samples `in_valid && in_last`. `out_valid` is high the following cycle, for exactly one cycle.
- `out_word`, `out_count` and `out_sat` hold their last values while `out_valid`=0.
- **Throughput:** one word per cycle, including back-to-back frames. A word arriving the cycle after `in_last` starts a new frame from EMPTY, concurrently with `out_valid`=1.
- **Back-to-back one-word frames:** `out_valid` stays high on consecutive cycles with a new value each cycle.
- `in_valid` may be asserted on any cycle; there is no ready signal.

## Test plan
- **Reset, then single-word frame** (`KEEP_MAX`=1): `in_word`=0x40302010 with `in_last`=1 -> next cycle `out_valid`=1, `out_word`=0x40302010, `out_count`=1, `out_sat`=0. The cycle after, `out_valid`=0.
- **Two-word merge:** 0x90605030 then 0x80706010 with `in_last` on the second -> `out_word`=0x90807060, `out_count`=2.
- **Gaps and duplicates:** 0x50505050, two idle cycles, 0x50504040 (last) -> `out_word`=0x50505050, `out_count`=2.
- **Min mode** (`KEEP_MAX`=0): 0x01030507 then 0x02040608 (last) -> `out_word`=0x01020304.
- **Reset mid-frame:** feed 0xFF000000, assert `rst_n`=0 for one cycle, then 0x10080402 (last) -> `out_word`=0x10080402, `out_count`=1, with no earlier `out_valid`.
- **Saturation** (`CNT_W`=2): five words, all 0x00000000, last on the fifth -> `out_count`=3, `out_sat`=1. A following one-word frame reports `out_sat`=0.
